sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
- Downstream stage of the APC stochastic neuron.
- Consumes the neuron's serial output bitstream `dout` and counts ones over a fixed window of L = 2^M valid samples.
- Presents the result as an unsigned unipolar count and a signed bipolar value, using a valid/ready handshake to the next binary-domain stage (readout, argmax, or next-layer SNG load).

Parameters:
- M, 8, log2 of the window length in samples.
- L, 2**M, window length (derived; do not override).

Ports:
- clk  input  1  system clock; samples are taken on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse that begins a new window (ignored while counting).
- sc_in  input  1  stochastic bitstream, driven by neuron dout.
- sc_en  input  1  sample qualifier; sc_in is counted only when sc_en=1.
- busy  output  1  high while a window is in progress.
- result_u  output  M+1  ones count in the window, range 0..L.
- result_b  output  M+2  signed bipolar value 2*count - L, range -L..+L.
- result_valid  output  1  result registers hold a completed window.
- result_ready  input  1  consumer accepts the result.

Behaviour:
- Async reset (reset=0):
  - state=IDLE.
  - ones counter and sample counter = 0.
  - result_u=0, result_b=0, result_valid=0, busy=0.
  - Reset mid-window aborts the window; no partial result is ever presented.
- Sampling: the neuron changes dout on negedge clk, so sc_in is stable at posedge. The decoder samples only at posedge.
- States:
  - IDLE, COUNT, DONE; 2-bit encoding.
- IDLE:
  - busy=0.
  - start=1 → clear ones counter and sample counter, go to COUNT.
  - The start cycle itself is not a sample.
- COUNT:
  - busy=1.
  - Each posedge with sc_en=1: sample counter += 1; ones counter += sc_in.
  - sc_en=0 → both counters hold (stall); no timeout.
  - When sc_en=1 and sample counter == L-1 (the last sample), the next-state values are:
    - result_u = ones + sc_in;
    - result_b = 2*(ones + sc_in) - L, computed sign-extended in M+2 bits;
    - state goes to DONE.
  - Latency: result_valid rises on the edge that takes the L-th valid sample; it is visible the next cycle.
  - start is ignored in COUNT.
- DONE:
  - busy=0, result_valid=1.
  - result_u and result_b are held stable until the handshake completes.
  - result_valid=1 && result_ready=1 → result_valid cleared at that edge.
    - start=1 in the same cycle → go directly to COUNT (back-to-back windows, no IDLE bubble); counters cleared.
    - Otherwise → IDLE.
  - start without result_ready → ignored; the result is never overwritten before acceptance.
- Width rules:
  - Ones counter is M+1 bits and cannot overflow, because at most L ones are counted.
  - Sample counter is M bits; it wraps only at the window end, where the wrap is consumed by the transition to DONE.
  - result_u and result_b keep their last accepted values in IDLE and are not cleared after a handshake.
- sc_in and sc_en are X-tolerant outside COUNT: they are don't-care in IDLE and DONE.

Decomposition:
- Shared package sc_pkg contains:
  - typedef enum logic [1:0] {DEC_IDLE, DEC_COUNT, DEC_DONE} sc_dec_state_t.
  - function to_bipolar(count, M), returning 2*count - 2^M as signed M+2 bits; reused by future decoders and SNG loaders.
- One sub-module is natural: sc_window_counter (M-bit sample counter with clear, enable and last-sample flag). Everything else stays in the top module.

Test Plan (bench with M=4, L=16):
- Reset and idle: reset=0 mid-run → all outputs 0 immediately (async); after release with no start → busy=0 and result_valid=0 indefinitely.
- All-ones and all-zeros windows: start, then 16 cycles of sc_in=1, sc_en=1 → result_u=16, result_b=+16, result_valid high on cycle 17. Repeat with sc_in=0 → result_u=0, result_b=-16.
- Half density with stalls: pattern 1010…, sc_en toggled 50% → window completes after 16 enabled samples (~32 cycles); result_u=8, result_b=0; busy stays high throughout.
- Backpressure: window of 12 ones, result_ready=0 for 10 cycles, start pulsed meanwhile → result_valid and result_u=12 (result_b=+8) held stable, no new window started. Then ready=1 → valid drops next cycle and state returns to IDLE.
- Back-to-back: result_ready=1 and start=1 in the same cycle → next window starts with no bubble and the second result follows exactly 16 enabled samples later. A start asserted during COUNT → count unaffected.
- Reset mid-window: after 7 samples, pulse reset → state returns to IDLE, no valid is produced. A new start then yields the correct full 16-sample count.

Source files
------------

// File: rtl/sc_pkg.sv
// sc_pkg: shared types and helpers for stochastic-computing decoders and loaders
package sc_pkg;
  localparam int SC_DEFAULT_M = 8;
  typedef enum logic [1:0] {DEC_IDLE, DEC_COUNT, DEC_DONE} sc_dec_state_t;
  // Maps a ones count over a 2^m window to the bipolar value 2*count - 2^m.
  // Returned 32 bits wide so callers can size-cast to their own M+2 width.
  function automatic logic signed [31:0] to_bipolar(input logic [31:0] count, input int m);
    return $signed((count << 1) - (32'd1 << m));
  endfunction
endpackage

// File: rtl/sc_window_counter.sv
// sc_window_counter: M-bit sample counter with clear, enable and last-sample flag
//   clk     system clock
//   reset   asynchronous active-low reset
//   clr_i   synchronous clear (takes priority over en_i)
//   en_i    count one sample
//   last_o  counter currently holds L-1, so the next enabled sample ends the window
module sc_window_counter #(
  parameter int M = 8,
  parameter int L = 2**M
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  logic [M-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign last_o = cnt_q == M'(L - 1);
endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts ones over a 2^M sample window and hands off unipolar/bipolar results
//   clk           system clock, sc_in sampled on rising edge
//   reset         asynchronous active-low reset
//   start         begin a new window (ignored while counting or holding an unaccepted result)
//   sc_in         stochastic bitstream
//   sc_en         sample qualifier
//   busy          window in progress
//   result_u      ones count, 0..L
//   result_b      signed 2*count - L
//   result_valid  result registers hold a completed window
//   result_ready  consumer accepts the result
import sc_pkg::*;
module sc_stream_decoder #(
  parameter int M = SC_DEFAULT_M
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sc_in,
  input  logic                sc_en,
  output logic                busy,
  output logic [M:0]          result_u,
  output logic signed [M+1:0] result_b,
  output logic                result_valid,
  input  logic                result_ready
);
  localparam int L = 2**M;
  sc_dec_state_t       state_q;
  logic [M:0]          ones_q, result_u_q, ones_nx;
  logic signed [M+1:0] result_b_q;
  logic                busy_q, valid_q, win_clr, win_en, win_last;
  assign win_clr = start && (state_q == DEC_IDLE || (state_q == DEC_DONE && result_ready));
  assign win_en  = state_q == DEC_COUNT && sc_en;
  assign ones_nx = ones_q + (M+1)'(sc_in);
  sc_window_counter #(.M(M), .L(L)) u_win (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (win_clr),
    .en_i   (win_en),
    .last_o (win_last)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DEC_IDLE;
      ones_q     <= '0;
      result_u_q <= '0;
      result_b_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        DEC_IDLE:
          if (start) begin
            ones_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= DEC_COUNT;
          end
        DEC_COUNT:
          if (sc_en) begin
            ones_q <= ones_nx;
            if (win_last) begin
              result_u_q <= ones_nx;
              result_b_q <= (M+2)'(to_bipolar(32'(ones_nx), M));
              busy_q     <= 1'b0;
              valid_q    <= 1'b1;
              state_q    <= DEC_DONE;
            end
          end
        DEC_DONE:
          if (result_ready) begin
            valid_q <= 1'b0;
            // accept and restart in one edge so consecutive windows have no idle gap
            if (start) begin
              ones_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= DEC_COUNT;
            end else begin
              state_q <= DEC_IDLE;
            end
          end
        default: state_q <= DEC_IDLE;
      endcase
    end
  end
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result_u     = result_u_q;
  assign result_b     = result_b_q;
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: table vectors, corner sequences and random traffic against a window model
module tb_sc_stream_decoder;
  localparam int M = 4;
  localparam int L = 16;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, sc_in = 1'b0, sc_en = 1'b0, result_ready = 1'b0;
  logic busy, result_valid;
  logic [M:0] result_u;
  logic signed [M+1:0] result_b;
  int total = 0, bad = 0;
  bit m_busy = 0, m_valid = 0;
  int m_u = 0, m_b = 0;
  bit samples[$];
  typedef struct {
    logic [15:0] pat;
    int          stall;
    int          exp_u;
    int          exp_b;
  } vec_t;
  vec_t vecs[6];

  sc_stream_decoder #(.M(M)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sc_in        (sc_in),
    .sc_en        (sc_en),
    .busy         (busy),
    .result_u     (result_u),
    .result_b     (result_b),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_u = 0; m_b = 0;
    samples.delete();
  endtask

  // Window-level model: collect enabled samples, publish sum when L have arrived.
  task automatic model_edge();
    int s;
    if (!reset) model_reset();
    else if (m_busy) begin
      if (sc_en) samples.push_back(sc_in);
      if (samples.size() == L) begin
        s = 0;
        foreach (samples[k]) s += samples[k];
        m_u = s; m_b = 2 * s - L;
        m_busy = 0; m_valid = 1;
      end
    end else if (m_valid) begin
      if (result_ready) begin
        m_valid = 0;
        if (start) begin m_busy = 1; samples.delete(); end
      end
    end else if (start) begin
      m_busy = 1; samples.delete();
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), int'(m_busy));
    chk("valid", 32'(result_valid), int'(m_valid));
    chk("result_u", 32'(result_u), m_u);
    chk("result_b", 32'(result_b), m_b);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_window(input logic [15:0] pat, input int stall);
    int i = 0, guard = 0;
    start = 1; sc_en = 0; step(); start = 0;
    while (i < L && guard < 2000) begin
      sc_en = $urandom_range(99) >= stall;
      sc_in = sc_en ? pat[i] : 1'($urandom);
      step();
      if (sc_en) i++;
      guard++;
    end
    if (i < L) begin
      $display("FAIL window_timeout actual=%0d required=%0d", i, L);
      bad++; total++;
    end
    sc_en = 0;
  endtask

  task automatic accept();
    result_ready = 1; step(); result_ready = 0;
    chk("accept_valid", 32'(result_valid), 0);
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 0, 16, 16};
    vecs[1] = '{16'h0000, 0, 0, -16};
    vecs[2] = '{16'hAAAA, 50, 8, 0};
    vecs[3] = '{16'h0FFF, 0, 12, 8};
    vecs[4] = '{16'h0001, 30, 1, -14};
    vecs[5] = '{16'h7FFF, 60, 15, 14};

    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(result_valid), 0);
    reset = 1;
    for (int i = 0; i < 5; i++) begin sc_en = 1'($urandom); sc_in = 1'($urandom); step(); end
    chk("idle_valid", 32'(result_valid), 0);

    foreach (vecs[v]) begin
      run_window(vecs[v].pat, vecs[v].stall);
      chk("tbl_valid", 32'(result_valid), 1);
      chk("tbl_u", 32'(result_u), vecs[v].exp_u);
      chk("tbl_b", 32'(result_b), vecs[v].exp_b);
      accept();
    end

    run_window(16'h0FFF, 0);
    for (int i = 0; i < 10; i++) begin start = (i % 3 == 0); step(); end
    start = 0;
    chk("bp_valid", 32'(result_valid), 1);
    chk("bp_busy", 32'(busy), 0);
    chk("bp_u", 32'(result_u), 12);
    chk("bp_b", 32'(result_b), 8);
    accept();
    step(); step();
    chk("bp_idle_busy", 32'(busy), 0);

    start = 1; step(); start = 0;
    for (int i = 0; i < 7; i++) begin sc_en = 1; sc_in = 1; step(); end
    #2 reset = 0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_valid", 32'(result_valid), 0);
    chk("async_u", 32'(result_u), 0);
    chk("async_b", 32'(result_b), 0);
    step();
    reset = 1;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_valid", 32'(result_valid), 0);
    run_window(16'hF0F0, 30);
    chk("post_rst_u", 32'(result_u), 8);
    chk("post_rst_b", 32'(result_b), 0);

    result_ready = 1; start = 1; step(); result_ready = 0; start = 0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_valid", 32'(result_valid), 0);
    for (int i = 0; i < L; i++) begin
      sc_en = 1; sc_in = 0; start = (i % 4 == 1); step();
      if (i < L - 1) chk("b2b_no_early", 32'(result_valid), 0);
    end
    start = 0; sc_en = 0;
    chk("b2b_valid2", 32'(result_valid), 1);
    chk("b2b_u", 32'(result_u), 0);
    chk("b2b_b", 32'(result_b), -16);
    accept();

    for (int i = 0; i < 1500; i++) begin
      start = $urandom_range(99) < 20;
      sc_en = $urandom_range(99) < 70;
      sc_in = 1'($urandom);
      result_ready = $urandom_range(99) < 40;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
